// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, one write port,
// optional write-to-read forwarding and a sequential clear sweep.
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              fwd_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    regs_d    = regs_q;
    unique case (state_q)
      IDLE: begin
        // clear wins over a simultaneous write
        if (clear) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          wr_drop_d = write;
        end else if (write) begin
          regs_d[writenum] = data_in;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        wr_drop_d     = write;
        if (&cnt_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      regs_q    <= regs_d;
    end
  end

  assign fwd_en = (BYPASS != 0) && (state_q == IDLE)
                  && write && !clear;

  assign data_out_a = (fwd_en && (readnum_a == writenum))
                      ? data_in : regs_q[readnum_a];
  assign data_out_b = (fwd_en && (readnum_b == writenum))
                      ? data_in : regs_q[readnum_b];

  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed check of regfile_mp against an array model,
// covering forwarding on and off with two instances sharing stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic        clear;
  logic [15:0] dout_a1, dout_b1, dout_a0, dout_b0;
  logic        busy1, busy0, drop1, drop0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [8];
  int          pos;
  bit          mdrop;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .clear(clear), .data_out_a(dout_a1), .data_out_b(dout_b1),
    .busy(busy1), .wr_drop(drop1)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .clear(clear), .data_out_a(dout_a0), .data_out_b(dout_b0),
    .busy(busy0), .wr_drop(drop0)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    pos   = -1;
    mdrop = 0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] ra,
                                         input bit byp);
    if (byp && pos < 0 && write && !clear && ra == writenum)
      return data_in;
    return mem[ra];
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".busy"}, 32'(busy1), 32'(pos >= 0));
    chk({tag, ".busy_nb"}, 32'(busy0), 32'(pos >= 0));
    chk({tag, ".drop"}, 32'(drop1), 32'(mdrop));
    chk({tag, ".drop_nb"}, 32'(drop0), 32'(mdrop));
    chk({tag, ".a"}, 32'(dout_a1), 32'(exp_rd(readnum_a, 1)));
    chk({tag, ".b"}, 32'(dout_b1), 32'(exp_rd(readnum_b, 1)));
    chk({tag, ".a_nb"}, 32'(dout_a0), 32'(exp_rd(readnum_a, 0)));
    chk({tag, ".b_nb"}, 32'(dout_b0), 32'(exp_rd(readnum_b, 0)));
  endtask

  task automatic model_edge();
    mdrop = 0;
    if (pos >= 0) begin
      mem[pos] = '0;
      mdrop = write;
      pos++;
      if (pos == 8) pos = -1;
    end else if (clear) begin
      pos   = 0;
      mdrop = write;
    end else if (write) begin
      mem[writenum] = data_in;
    end
  endtask

  // one clock cycle: drive, check before the edge, advance the model
  task automatic cyc(input string tag, input bit w, input logic [2:0] wn,
                     input logic [15:0] din, input logic [2:0] ra,
                     input logic [2:0] rb, input bit clr);
    write     = w;
    writenum  = wn;
    data_in   = din;
    readnum_a = ra;
    readnum_b = rb;
    clear     = clr;
    #1;
    check_outs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    write = 0;
    clear = 0;
    for (int i = 0; i < 4; i++) begin
      readnum_a = 3'(i);
      readnum_b = 3'(i + 4);
      #1;
      check_outs(tag);
    end
  endtask

  initial begin
    int n;
    rst_n = 0; data_in = '0; writenum = '0; write = 0;
    readnum_a = '0; readnum_b = '0; clear = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    cyc("byp_w3", 1, 3, 16'h00FF, 3, 3, 0);
    cyc("byp_rd3", 0, 0, 16'h0, 3, 0, 0);
    chk("byp_after_nb", 32'(dout_a0), 32'h00FF);

    cyc("w5", 1, 5, 16'h1234, 0, 0, 0);
    cyc("w2", 1, 2, 16'hABCD, 0, 0, 0);
    cyc("rd52", 0, 0, 16'h0, 5, 2, 0);
    chk("r5", 32'(dout_a1), 32'h1234);
    chk("r2", 32'(dout_b1), 32'hABCD);

    for (int i = 0; i < 8; i++)
      cyc("fill", 1, 3'(i), 16'(16'h1111 * (i + 1)), 0, 7, 0);
    cyc("clr_w", 1, 4, 16'hBEEF, 0, 7, 1);
    n = 0;
    while (busy1 && n < 20) begin
      cyc("sweep", n == 3, 4, 16'h5555, 0, 7, n == 3);
      n++;
      if (n == 2) begin
        chk("r0_swept", 32'(dout_a1), 32'h0);
        chk("r7_kept", 32'(dout_b1), 32'h8888);
      end
    end
    chk("busy_len", 32'(n), 32'd8);
    check_all("post_sweep");

    for (int i = 0; i < 8; i++)
      cyc("refill", 1, 3'(i), 16'(16'hA000 + i), 3'(i), 0, 0);
    cyc("clr2", 0, 0, 16'h0, 0, 0, 1);
    cyc("mid", 0, 0, 16'h0, 1, 6, 0);
    cyc("mid", 0, 0, 16'h0, 1, 6, 0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    rst_n = 1;
    cyc("w_after_rst", 1, 6, 16'h7777, 6, 6, 0);
    cyc("rd_after_rst", 0, 0, 16'h0, 6, 6, 0);
    chk("r6_after_rst", 32'(dout_a0), 32'h7777);

    for (int k = 0; k < 300; k++) begin
      cyc("rand", 1'($urandom_range(0, 1)), 3'($urandom),
          16'($urandom), 3'($urandom), 3'($urandom),
          $urandom_range(0, 11) == 0);
    end
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each register and data port.
REQ-002 SHALL have parameter ADDR_W, default 3: register address width; DEPTH = 2^ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port data_in, input, DATA_W: write data.
REQ-007 SHALL have port writenum, input, ADDR_W: write address.
REQ-008 SHALL have port write, input, 1: write request for the current cycle.
REQ-009 SHALL have port readnum_a, input, ADDR_W: read port A address.
REQ-010 SHALL have port readnum_b, input, ADDR_W: read port B address.
REQ-011 SHALL have port clear, input, 1: request to start a sequential clear sweep.
REQ-012 SHALL have port data_out_a, output, DATA_W: read port A data.
REQ-013 SHALL have port data_out_b, output, DATA_W: read port B data.
REQ-014 SHALL have port busy, output, 1: high while a clear sweep is in progress.
REQ-015 SHALL have port wr_drop, output, 1: one-cycle pulse marking a write that was discarded.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and CLEAR. busy = (state == CLEAR), driven from a register.
REQ-017 SHALL, in IDLE with write=1 and clear=0, load data_in into register[writenum] at the rising edge.
REQ-018 SHALL leave every register not addressed by an accepted write or by the sweep unchanged.
REQ-019 SHALL drive data_out_a and data_out_b combinationally from register[readnum_a] and register[readnum_b].
REQ-020 SHALL support both read ports reading any addresses independently, including the same address.
REQ-021 SHALL forward data_in instead of the stored value on a read port when all of these hold: BYPASS=1, state=IDLE, write=1, clear=0, and that port's readnum equals writenum.
REQ-022 SHALL never forward when BYPASS=0; reads then show the new value only after the write edge.
REQ-023 SHALL, in IDLE with clear=1 at a rising edge, enter CLEAR with the sweep counter at 0; no register changes at that edge.
REQ-024 SHALL, in CLEAR, zero register[counter] at each rising edge and increment the counter; when counter = DEPTH-1, zero the last register and return to IDLE at that edge.
REQ-025 SHALL therefore hold busy high for exactly DEPTH cycles per sweep.
REQ-026 SHALL make the sweep counter ADDR_W bits wide; it SHALL never wrap within a sweep.
REQ-027 SHALL give clear priority over write when both are high in IDLE: the sweep starts and the write is discarded.
REQ-028 SHALL discard any write requested while state=CLEAR.
REQ-029 SHALL ignore clear while state=CLEAR; the sweep neither restarts nor extends.
REQ-030 SHALL, for every discarded write, assert wr_drop for exactly the one cycle following the rising edge at which the write was discarded; otherwise wr_drop=0.
REQ-031 SHALL, during CLEAR, return stored contents on reads: already-swept registers read 0, unswept registers read their old values.

Reset
REQ-032 SHALL, while rst_n=0 and regardless of clk, set all registers to 0, state to IDLE, sweep counter to 0, busy to 0 and wr_drop to 0.
REQ-033 SHALL abort an in-progress sweep on reset; after rst_n rises the block is in IDLE with all registers 0.
REQ-034 SHALL accept a write at the first rising edge after rst_n deasserts.

Verification
REQ-035 Reset, then write 16'h1234 to R5 and 16'hABCD to R2; set readnum_a=5, readnum_b=2 -> data_out_a=16'h1234, data_out_b=16'hABCD.
REQ-036 BYPASS=1: write=1, writenum=3, data_in=16'h00FF, readnum_a=3, with R3=0 before the edge -> data_out_a=16'h00FF in the same cycle; with BYPASS=0 -> 0 until the edge, then 16'h00FF.
REQ-037 Fill R0..R7 with nonzero values, pulse clear -> busy high for exactly 8 cycles; R0 reads 0 after the 2nd edge while R7 still holds its value; all registers read 0 once busy falls.
REQ-038 Assert write together with clear in IDLE, and again mid-sweep -> target register not written (0 after the sweep) and wr_drop pulses one cycle after each of those edges.
REQ-039 Pulse clear again mid-sweep -> busy still falls DEPTH cycles after the original start.
REQ-040 Drop rst_n asynchronously between edges mid-sweep -> busy=0 and all registers 0 immediately; a write at the first edge after release lands correctly.
